// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced N-to-2^N decoder.
package decoder_pkg;

   localparam int DEC_IN_W  = 5;
   localparam int DEC_OUT_W = 2 ** DEC_IN_W;

   typedef enum logic {S_IDLE, S_SWEEP} dec_state_t;

   function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_IN_W-1:0] idx);
      return DEC_OUT_W'(1) << idx;
   endfunction

endpackage

// File: rtl/decoder_nx2n.sv
// Combinational index-to-one-hot decoder with enable and an optional
// masked index that never asserts its output bit.
module decoder_nx2n
   import decoder_pkg::*;
#(
   parameter int IN_W     = DEC_IN_W,
   parameter bit MASK_EN  = 1'b0,
   parameter int MASK_IDX = 2 ** IN_W - 1
) (
   input  logic [IN_W-1:0]      idx,
   input  logic                 en,
   output logic [2**IN_W-1:0]   onehot_out
);

   localparam int OUT_W = 2 ** IN_W;
   localparam logic [IN_W-1:0] MASK_IDX_W = IN_W'(MASK_IDX);

   logic [OUT_W-1:0] raw;
   logic             masked;

   generate
      if (IN_W == DEC_IN_W) begin : g_pkg_width
         assign raw = onehot(idx);
      end else begin : g_any_width
         assign raw = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
      end
   endgenerate

   assign masked     = MASK_EN && (idx == MASK_IDX_W);
   assign onehot_out = (en && !masked) ? raw : '0;

endmodule

// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-2^N write-enable decoder with request handshake and a
// power-up sweep mode. Define DECODER_ZERO_REG_MASK_EN to mask index ZERO_IDX.
module decoder_seq_nx2n
   import decoder_pkg::*;
#(
   parameter int IN_W     = DEC_IN_W,
   parameter int ZERO_IDX = 2 ** IN_W - 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [IN_W-1:0]      in_idx,
   input  logic                 in_en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 sweep_start,
   output logic                 sweep_busy,
   output logic                 sweep_done,
   output logic [2**IN_W-1:0]   out,
   output logic                 out_valid
);

   localparam int OUT_W = 2 ** IN_W;
`ifdef DECODER_ZERO_REG_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif
   localparam logic [IN_W:0] CNT_ONE  = (IN_W+1)'(1);
   localparam logic [IN_W:0] CNT_LAST = (IN_W+1)'(OUT_W - 1);
   localparam logic [IN_W:0] CNT_END  = (IN_W+1)'(OUT_W);

   dec_state_t       state_q, state_d;
   logic [IN_W:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             sweep_done_q, sweep_done_d;
   logic [IN_W-1:0]  dec_idx;
   logic             dec_en;
   logic [OUT_W-1:0] dec_out;

   decoder_nx2n #(
      .IN_W     (IN_W),
      .MASK_EN  (MASK_EN),
      .MASK_IDX (ZERO_IDX)
   ) u_dec (
      .idx        (dec_idx),
      .en         (dec_en),
      .onehot_out (dec_out)
   );

   assign in_ready   = (state_q == S_IDLE) && !sweep_start;
   assign sweep_busy = (state_q == S_SWEEP);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sweep_done_d = 1'b0;
      dec_idx      = in_idx;
      dec_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sweep_start) begin
               dec_idx = '0;
               dec_en  = 1'b1;
               cnt_d   = CNT_ONE;
               state_d = S_SWEEP;
            end else if (in_valid && in_en) begin
               dec_en = 1'b1;
            end
         end
         S_SWEEP: begin
            // The counter runs one past the last index so the return-to-idle
            // edge can be recognised without an extra state.
            if (cnt_q == CNT_END) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               dec_idx      = cnt_q[IN_W-1:0];
               dec_en       = 1'b1;
               cnt_d        = cnt_q + CNT_ONE;
               sweep_done_d = (cnt_q == CNT_LAST);
            end
         end
         default: state_d = S_IDLE;
      endcase
      out_d       = dec_out;
      out_valid_d = |dec_out;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         sweep_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         sweep_done_q <= sweep_done_d;
      end
   end

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign sweep_done = sweep_done_q;

endmodule

// File: doc/decoder_seq_nx2n.md
Name: decoder_seq_nx2n

Overview:
- Parametrised, registered successor to the fixed 5-to-32 enable-gated decoder.
- Converts an IN_W-bit index into a 2^IN_W one-hot word with one cycle of latency, behind a valid/ready request handshake.
- Adds a sweep mode that walks every output index once, one per cycle, so the register file can be cleared after reset.
- Drives register-file write-enable lines in the CPU datapath.

Parameters:
- IN_W, 5, index width; output width OUT_W = 2**IN_W is a derived localparam, not overridable.
- ZERO_IDX, 2**IN_W-1, index treated as the hardwired zero register (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_idx  input  IN_W  index to decode.
- in_en  input  1  per-request enable; 0 gives an all-zero decode.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted this cycle when in_valid & in_ready.
- sweep_start  input  1  single-cycle pulse that starts a full sweep.
- sweep_busy  output  1  sweep in progress.
- sweep_done  output  1  pulse coincident with the last sweep output.
- out  output  OUT_W  registered one-hot (or zero) word.
- out_valid  output  1  out carries a live one-hot this cycle.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset reset_n is asynchronous, active-low.
  - On reset: out=0, out_valid=0, sweep_done=0, sweep_busy=0, FSM=S_IDLE, sweep counter=0.
  - Reset asserted mid-sweep aborts immediately; no sweep_done pulse.
- FSM states: S_IDLE, S_SWEEP.
- in_ready is combinational: (state==S_IDLE) & ~sweep_start.
- S_IDLE, at each rising edge:
  - If sweep_start=1:
    - out<=onehot(0), out_valid<=1, counter<=1, state<=S_SWEEP.
    - sweep_start has priority over a simultaneous in_valid; that request is not accepted (in_ready=0).
  - Else if in_valid=1 and in_en=1: out<=onehot(in_idx), out_valid<=1.
  - Else if in_valid=1 and in_en=0: request accepted; out<=0, out_valid<=0.
  - Else: out<=0, out_valid<=0.
  - Latency is exactly 1 cycle. Outputs persist for one cycle only; there is no output backpressure.
- S_SWEEP, at each rising edge:
  - out<=onehot(counter), out_valid<=1, counter<=counter+1.
  - When counter==OUT_W-1 is loaded into out, sweep_done<=1 for that cycle.
  - On the following edge: state<=S_IDLE, out<=0, out_valid<=0, sweep_done<=0, counter<=0.
  - sweep_busy=1 exactly while state==S_SWEEP.
  - Total sweep = OUT_W consecutive out_valid cycles: index 0 through OUT_W-1, in order, no gaps.
  - sweep_start during S_SWEEP is ignored; no restart.
  - in_valid during S_SWEEP is stalled (in_ready=0). The requester holds the request; nothing is dropped.
- Width rules:
  - counter is IN_W+1 bits so the terminal compare does not wrap.
  - onehot(k) = 1 << k, truncated to OUT_W bits.
  - Out-of-range k cannot occur.

Optional Feature:
- Macro: DECODER_ZERO_REG_MASK_EN.
- Defined:
  - Index ZERO_IDX never asserts its out bit.
  - A decode request for ZERO_IDX is accepted with out=0, out_valid=0.
  - During a sweep, the ZERO_IDX cycle gives out=0, out_valid=0. The counter still advances, sweep length is unchanged at OUT_W cycles, and sweep_done still pulses on the index OUT_W-1 cycle (out=0 if ZERO_IDX=OUT_W-1).
- Undefined: all indices decode normally; ZERO_IDX is unused.

Decomposition:
- Package decoder_pkg holds:
  - typedef enum logic {S_IDLE, S_SWEEP} dec_state_t.
  - function automatic onehot(idx) parametrised via IN_W.
  - localparam default DEC_IN_W=5.
- One natural sub-module: decoder_nx2n, the purely combinational parametric index-to-one-hot decoder with an enable. Instantiate it once, fed by a mux of in_idx or the counter.

Test Plan:
- Reset: hold reset_n=0 with clk running -> out=0, out_valid=0, sweep_busy=0, in_ready=1.
- Decode: in_idx=5, in_en=1, in_valid=1 for one cycle -> next cycle out=32'h0000_0020, out_valid=1; following cycle out=0.
- Enable low: in_idx=9, in_en=0 -> in_ready=1, next cycle out=0, out_valid=0.
- Full sweep:
  - Pulse sweep_start -> 32 consecutive cycles out=1<<0 … 1<<31, sweep_busy=1.
  - sweep_done=1 only with out=32'h8000_0000; then idle.
  - A request held during the sweep is served the cycle after return to idle.
- Priority and abort:
  - sweep_start and in_valid (in_idx=3) in the same cycle -> sweep wins; request is accepted later.
  - Assert reset_n=0 at sweep index 10 -> outputs clear immediately, no sweep_done.
- With DECODER_ZERO_REG_MASK_EN (ZERO_IDX=31):
  - Decode of in_idx=31 -> out=0, out_valid=0.
  - Sweep -> 31 valid cycles plus a final cycle with out=0, out_valid=0, sweep_done=1.
